// File: rtl/fp_align_seq_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fp_align_seq_if : operand-in / aligned-pair-out handshake bundle
// Revision: 1.0
// ---------------------------------------------------------------------------
interface fp_align_seq_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a_bits;
   logic [31:0] b_bits;
   logic        out_valid;
   logic        out_ready;
   logic        sign_big;
   logic        sign_small;
   logic        eff_sub;
   logic [7:0]  exp_out;
   logic [23:0] mant_big;
   logic [26:0] mant_small;
   logic        special;

   modport master (
      output in_valid, a_bits, b_bits, out_ready,
      input  in_ready, out_valid, sign_big, sign_small, eff_sub,
             exp_out, mant_big, mant_small, special
   );

   modport slave (
      input  in_valid, a_bits, b_bits, out_ready,
      output in_ready, out_valid, sign_big, sign_small, eff_sub,
             exp_out, mant_big, mant_small, special
   );
endinterface
`default_nettype wire

// File: rtl/fp_align_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fp_align_seq : orders an FP32 operand pair by magnitude and right-aligns the
//                smaller mantissa SHIFT_STEP bits per cycle with G/R/S bits.
// Revision: 1.0
// ---------------------------------------------------------------------------
module fp_align_seq #(
   parameter int SHIFT_STEP = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   fp_align_seq_if.slave  bus
);

   localparam logic [4:0] STEP     = 5'(SHIFT_STEP);
   localparam logic [4:0] MAX_DIFF = 5'd27;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_HOLD  = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic        sign_big_q, sign_big_d;
   logic        sign_small_q, sign_small_d;
   logic [7:0]  exp_q, exp_d;
   logic [23:0] mant_big_q, mant_big_d;
   logic [26:0] mant_small_q, mant_small_d;
   logic        special_q, special_d;
   logic [4:0]  rem_q, rem_d;

   // Unpack
   logic [7:0]  a_exp, b_exp, a_eexp, b_eexp;
   logic [22:0] a_frac, b_frac;
   logic        a_hid, b_hid, a_is_big, cap_special;
   logic [7:0]  big_eexp, small_eexp, diff_raw;
   logic [4:0]  diff_clamp;

   assign a_exp  = bus.a_bits[30:23];
   assign b_exp  = bus.b_bits[30:23];
   assign a_frac = bus.a_bits[22:0];
   assign b_frac = bus.b_bits[22:0];
   assign a_hid  = (a_exp != 8'd0);
   assign b_hid  = (b_exp != 8'd0);
   assign a_eexp = a_hid ? a_exp : 8'd1;
   assign b_eexp = b_hid ? b_exp : 8'd1;

   // Ties favour A as the big operand.
   assign a_is_big    = ({a_eexp, a_frac} >= {b_eexp, b_frac});
   assign cap_special = (a_exp == 8'hFF) || (b_exp == 8'hFF);
   assign big_eexp    = a_is_big ? a_eexp : b_eexp;
   assign small_eexp  = a_is_big ? b_eexp : a_eexp;
   assign diff_raw    = big_eexp - small_eexp;
   assign diff_clamp  = (diff_raw > 8'(MAX_DIFF)) ? MAX_DIFF : diff_raw[4:0];

   // One shift step: bits pushed out fold into the sticky position.
   logic [4:0]  shift_k;
   logic [26:0] lost_mask, shifted_base, mant_shifted;
   logic        sticky_out;

   assign shift_k      = (rem_q < STEP) ? rem_q : STEP;
   assign lost_mask    = ~({27{1'b1}} << shift_k);
   assign shifted_base = mant_small_q >> shift_k;
   assign sticky_out   = |(mant_small_q & lost_mask);
   assign mant_shifted = {shifted_base[26:1], shifted_base[0] | sticky_out};

   always_comb begin
      state_d      = state_q;
      sign_big_d   = sign_big_q;
      sign_small_d = sign_small_q;
      exp_d        = exp_q;
      mant_big_d   = mant_big_q;
      mant_small_d = mant_small_q;
      special_d    = special_q;
      rem_d        = rem_q;

      case (state_q)
         ST_IDLE: begin
            if (bus.in_valid) begin
               sign_big_d   = a_is_big ? bus.a_bits[31] : bus.b_bits[31];
               sign_small_d = a_is_big ? bus.b_bits[31] : bus.a_bits[31];
               exp_d        = cap_special ? 8'hFF : big_eexp;
               mant_big_d   = a_is_big ? {a_hid, a_frac} : {b_hid, b_frac};
               mant_small_d = a_is_big ? {b_hid, b_frac, 3'b000}
                                       : {a_hid, a_frac, 3'b000};
               special_d    = cap_special;
               rem_d        = diff_clamp;
               state_d      = (cap_special || diff_clamp == 5'd0) ? ST_HOLD : ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            mant_small_d = mant_shifted;
            rem_d        = rem_q - shift_k;
            if (rem_q == shift_k) begin
               state_d = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (bus.out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         sign_big_q   <= 1'b0;
         sign_small_q <= 1'b0;
         exp_q        <= 8'd0;
         mant_big_q   <= 24'd0;
         mant_small_q <= 27'd0;
         special_q    <= 1'b0;
         rem_q        <= 5'd0;
      end else begin
         state_q      <= state_d;
         sign_big_q   <= sign_big_d;
         sign_small_q <= sign_small_d;
         exp_q        <= exp_d;
         mant_big_q   <= mant_big_d;
         mant_small_q <= mant_small_d;
         special_q    <= special_d;
         rem_q        <= rem_d;
      end
   end

   assign bus.in_ready   = (state_q == ST_IDLE);
   assign bus.out_valid  = (state_q == ST_HOLD);
   assign bus.sign_big   = sign_big_q;
   assign bus.sign_small = sign_small_q;
   assign bus.eff_sub    = sign_big_q ^ sign_small_q;
   assign bus.exp_out    = exp_q;
   assign bus.mant_big   = mant_big_q;
   assign bus.mant_small = mant_small_q;
   assign bus.special    = special_q;

endmodule
`default_nettype wire

// File: tb/tb_fp_align_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fp_align_seq : directed plus randomized checks of fp_align_seq against
//                   an arithmetic alignment model.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_fp_align_seq;

   localparam int STEP = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fp_align_seq_if bus ();

   fp_align_seq #(.SHIFT_STEP(STEP)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int passed = 0;
   int total  = 0;
   int failed = 0;

   typedef struct {
      logic        sb;
      logic        ss;
      logic        es;
      logic        sp;
      logic [7:0]  ex;
      logic [23:0] mb;
      logic [26:0] ms;
      int          lat;
   } ref_t;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) passed++;
      else begin
         failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Alignment as plain integer arithmetic: shift the whole value at once and
   // fold any nonzero remainder into the sticky bit.
   function automatic ref_t ref_model(input logic [31:0] a, input logic [31:0] b);
      ref_t        r;
      int          ea, eb, eg, es, d;
      longint      ka, kb, m, keep, lost;
      logic        a_big;
      logic [31:0] bg, sm;
      ea    = (a[30:23] == 8'd0) ? 1 : int'(a[30:23]);
      eb    = (b[30:23] == 8'd0) ? 1 : int'(b[30:23]);
      ka    = longint'(ea) * 8388608 + longint'(a[22:0]);
      kb    = longint'(eb) * 8388608 + longint'(b[22:0]);
      a_big = (ka >= kb);
      bg    = a_big ? a : b;
      sm    = a_big ? b : a;
      eg    = a_big ? ea : eb;
      es    = a_big ? eb : ea;
      r.sb  = bg[31];
      r.ss  = sm[31];
      r.es  = bg[31] ^ sm[31];
      r.sp  = (a[30:23] == 8'hFF) || (b[30:23] == 8'hFF);
      r.mb  = {(bg[30:23] != 8'd0), bg[22:0]};
      m     = (longint'(sm[30:23] != 8'd0) * 8388608 + longint'(sm[22:0])) * 8;
      d     = eg - es;
      if (d > 27) d = 27;
      if (r.sp) begin
         r.ex  = 8'hFF;
         r.ms  = 27'(m);
         r.lat = 1;
      end else begin
         keep  = m >> d;
         lost  = m - (keep << d);
         r.ex  = 8'(eg);
         r.ms  = 27'(keep | ((lost != 0) ? 64'd1 : 64'd0));
         r.lat = (d == 0) ? 1 : 1 + (d + STEP - 1) / STEP;
      end
      return r;
   endfunction

   task automatic check_outputs(input string tag, input ref_t r);
      chk({tag, ".sign_big"},   32'(bus.sign_big),   32'(r.sb));
      chk({tag, ".sign_small"}, 32'(bus.sign_small), 32'(r.ss));
      chk({tag, ".eff_sub"},    32'(bus.eff_sub),    32'(r.es));
      chk({tag, ".special"},    32'(bus.special),    32'(r.sp));
      chk({tag, ".exp_out"},    32'(bus.exp_out),    32'(r.ex));
      chk({tag, ".mant_big"},   32'(bus.mant_big),   32'(r.mb));
      chk({tag, ".mant_small"}, 32'(bus.mant_small), 32'(r.ms));
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, ".in_ready"},   32'(bus.in_ready),   32'd1);
      chk({tag, ".out_valid"},  32'(bus.out_valid),  32'd0);
      chk({tag, ".sign_big"},   32'(bus.sign_big),   32'd0);
      chk({tag, ".sign_small"}, 32'(bus.sign_small), 32'd0);
      chk({tag, ".eff_sub"},    32'(bus.eff_sub),    32'd0);
      chk({tag, ".special"},    32'(bus.special),    32'd0);
      chk({tag, ".exp_out"},    32'(bus.exp_out),    32'd0);
      chk({tag, ".mant_big"},   32'(bus.mant_big),   32'd0);
      chk({tag, ".mant_small"}, 32'(bus.mant_small), 32'd0);
   endtask

   // One full transaction: capture, latency, result, backpressure, release.
   // During backpressure and on the release cycle in_valid carries junk that
   // must be ignored.
   task automatic do_txn(input logic [31:0] a, input logic [31:0] b, input int hold);
      ref_t r;
      int   lat;
      r = ref_model(a, b);
      @(negedge clk);
      chk("idle.in_ready", 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b1;
      bus.a_bits   = a;
      bus.b_bits   = b;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.a_bits   = $urandom;
      bus.b_bits   = $urandom;
      lat = 1;
      while (bus.out_valid !== 1'b1 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      chk("latency", 32'(lat), 32'(r.lat));
      check_outputs("result", r);
      chk("busy.in_ready", 32'(bus.in_ready), 32'd0);
      for (int i = 0; i < hold; i++) begin
         bus.in_valid = 1'b1;
         bus.a_bits   = $urandom;
         bus.b_bits   = $urandom;
         @(negedge clk);
         bus.in_valid = 1'b0;
         check_outputs("hold", r);
         chk("hold.out_valid", 32'(bus.out_valid), 32'd1);
         chk("hold.in_ready",  32'(bus.in_ready),  32'd0);
      end
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.a_bits    = $urandom;
      bus.b_bits    = $urandom;
      @(negedge clk);
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b0;
      chk("release.out_valid", 32'(bus.out_valid), 32'd0);
      chk("release.in_ready",  32'(bus.in_ready),  32'd1);
      check_outputs("release", r);
   endtask

   initial begin
      logic [31:0] ra, rb, tmp;
      int          mode, e;

      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.a_bits    = 32'd0;
      bus.b_bits    = 32'd0;
      rst_n         = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      check_reset_state("reset");

      do_txn(32'h3F800000, 32'h3F800000, 0);
      chk("equal.exp_out",    32'(bus.exp_out),    32'h7F);
      chk("equal.mant_big",   32'(bus.mant_big),   32'h800000);
      chk("equal.mant_small", 32'(bus.mant_small), 32'h4000000);

      do_txn(32'h3F800000, 32'h40000000, 1);
      chk("swap.exp_out",    32'(bus.exp_out),    32'h80);
      chk("swap.mant_small", 32'(bus.mant_small), 32'h2000000);

      do_txn(32'hBF920000, 32'h3F921000, 0);
      chk("cancel.eff_sub",    32'(bus.eff_sub),    32'd1);
      chk("cancel.mant_big",   32'(bus.mant_big),   32'h921000);
      chk("cancel.mant_small", 32'(bus.mant_small), 32'h4900000);

      do_txn(32'h4B800000, 32'h3F800001, 0);
      chk("diff24.mant_small", 32'(bus.mant_small), 32'h5);

      do_txn(32'h7F000000, 32'h3F800000, 0);
      chk("diff27.mant_small", 32'(bus.mant_small), 32'h1);

      do_txn(32'h7F800000, $urandom, 5);
      chk("special.special", 32'(bus.special), 32'd1);
      chk("special.exp_out", 32'(bus.exp_out), 32'hFF);

      // Reset while the diff-24 case is shifting.
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.a_bits   = 32'h4B800000;
      bus.b_bits   = 32'h3F800001;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("midshift.out_valid", 32'(bus.out_valid), 32'd0);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check_reset_state("midreset");
      do_txn(32'h3F800000, 32'h3F800000, 0);
      chk("postreset.mant_small", 32'(bus.mant_small), 32'h4000000);

      for (int n = 0; n < 150; n++) begin
         ra   = $urandom;
         mode = int'($urandom_range(0, 3));
         case (mode)
            0: rb = $urandom;
            1: begin
               e = int'(ra[30:23]) - int'($urandom_range(0, 30));
               if (e < 0) e = 0;
               rb = {1'($urandom_range(0, 1)), 8'(e), 23'($urandom)};
            end
            2: rb = ($urandom_range(0, 3) == 0) ? ra
                    : {1'($urandom_range(0, 1)), ra[30:23], 23'($urandom)};
            default: rb = {1'($urandom_range(0, 1)), 8'h00,
                           ($urandom_range(0, 1) == 0) ? 23'd0 : 23'($urandom)};
         endcase
         if ($urandom_range(0, 1) == 1) begin
            tmp = ra;
            ra  = rb;
            rb  = tmp;
         end
         do_txn(ra, rb, int'($urandom_range(0, 2)));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
`default_nettype wire
